lc3b_mem_arbiter: RTL and testbench
===================================

// Module: lc3b_mem_arbiter
// PURPOSE
//  Shares one physical-memory line port between the I-side (fetch) and D-side (mem_stage) cache misses.
//  Sits below both L1 caches, outside the 5-stage pipeline.
//  Serialises misses through a small FSM and registers the winning request onto pmem.
//  Steers pmem_resp back to the owner only.
// PARAMETERS
//  ADDR_W        16   byte address width (lc3b_word)
//  LINE_W        128  cache line width in bits; OFS_W = log2(LINE_W/8) = 4
//  STARVE_LIMIT  4    consecutive D grants tolerated while I waits (guard feature only)
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  i_read        in   1       I-cache line read request, held until i_resp
//  i_address     in   ADDR_W  I-side miss address
//  i_rdata       out  LINE_W  line data to I-cache (= pmem_rdata)
//  i_resp        out  1       one-cycle completion pulse to I-cache
//  d_read        in   1       D-cache line read request, held until d_resp
//  d_write       in   1       D-cache line writeback request, held until d_resp
//  d_address     in   ADDR_W  D-side miss/writeback address
//  d_wdata       in   LINE_W  writeback line
//  d_rdata       out  LINE_W  line data to D-cache (= pmem_rdata)
//  d_resp        out  1       one-cycle completion pulse to D-cache
//  pmem_read     out  1       memory read strobe, held until pmem_resp
//  pmem_write    out  1       memory write strobe, held until pmem_resp
//  pmem_address  out  ADDR_W  line-aligned address, low OFS_W bits forced 0
//  pmem_wdata    out  LINE_W  registered write line
//  pmem_rdata    in   LINE_W  memory read line
//  pmem_resp     in   1       memory completion, one cycle
//  arb_owner     out  2       00 idle, 01 I, 10 D, 11 done-bubble (debug/perf)
// BEHAVIOUR
//  Reset (async): state IDLE.
//    pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp = 0.
//    arb_owner = 00; starve counter = 0.
//  FSM states: IDLE -> BUSY_I | BUSY_D -> DONE -> IDLE.
//  IDLE: sample requests at the rising edge.
//    D wins if (d_read|d_write); else I wins if i_read; else stay IDLE.
//    On grant, register address (aligned), wdata (D write only) and op.
//    pmem strobe rises the cycle after the grant edge (1-cycle grant latency).
//  BUSY_x: hold pmem strobes/address/wdata stable.
//    Requester inputs are not re-sampled.
//    On pmem_resp=1: assert x_resp combinationally in the same cycle, drop strobes at the edge, go DONE.
//  DONE: one bubble cycle. No grant, no strobes.
//    Gives the requester one edge to deassert its request; then IDLE.
//  d_read & d_write together: treated as write (writeback precedes refill).
//  pmem_resp in IDLE/DONE: ignored; no x_resp generated.
//  i_rdata/d_rdata always mirror pmem_rdata; only x_resp qualifies them.
//  Minimum transaction: grant edge + pmem latency + resp cycle + DONE.
//    Back-to-back grants are at least 3 cycles apart.
//  Reset asserted mid-BUSY: transaction abandoned, strobes drop immediately.
//    A late pmem_resp after reset release is ignored.
// CONFIGURATION
//  LC3B_ARB_STARVE_GUARD_EN defined:
//    A 3-bit counter increments on each D grant made while i_read=1.
//    It clears on any I grant, or in IDLE when i_read=0.
//    When counter == STARVE_LIMIT and both sides request, I wins and the counter clears.
//  Not defined: strict D priority; counter logic absent.
//    I may starve indefinitely under continuous D traffic.
// TESTING
//  T1 reset:
//    rst_n=0 mid-BUSY_D -> all outputs 0 within same cycle.
//    After release, a stray pmem_resp gives no i_resp/d_resp.
//  T2 single I miss:
//    i_read=1, i_address=16'h3A57 -> next cycle pmem_read=1, pmem_address=16'h3A50.
//    pmem_resp at +5 -> i_resp=1 that cycle; d_resp=0; pmem_read=0 next cycle.
//  T3 simultaneous:
//    i_read & d_write (d_address=16'h1008, d_wdata=128'hA5..A5) same edge.
//    -> pmem_write first with address 16'h1000 and wdata A5..A5.
//    Then DONE; then pmem_read for I.
//  T4 read+write:
//    d_read=d_write=1 -> pmem_write=1, pmem_read=0.
//  T5 hold stability:
//    Change i_address during BUSY_I -> pmem_address unchanged until pmem_resp.
//  T6 starvation (guard on, STARVE_LIMIT=4):
//    d_read held plus i_read held -> grant order D,D,D,D,I.
//    Guard off: D only for 10 grants, i_resp never pulses.

Source files
------------

// File: rtl/lc3b_mem_arbiter_if.sv
// Cache-side miss handshakes plus the shared physical-memory line port.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface lc3b_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Serialises I-side and D-side cache line misses onto one pmem port (D priority).
// Define LC3B_ARB_STARVE_GUARD_EN to let I win after STARVE_LIMIT consecutive D grants.
module lc3b_mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3b_mem_arbiter_if.slave bus,
  output logic [1:0]        arb_owner
);
  localparam int unsigned OFS_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   d_req;
  logic   grant_i, grant_d;
  logic   starve_hit;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must fit the 3-bit starve counter");
  end

  assign d_req = bus.d_read | bus.d_write;

`ifdef LC3B_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign starve_hit = bus.i_read && (starve_cnt == 3'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && bus.i_read) begin
      starve_cnt <= starve_cnt + 3'd1;
    end else if (state_q == IDLE && !bus.i_read) begin
      starve_cnt <= '0;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !starve_hit) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (bus.i_read) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.pmem_resp) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request inputs are captured only on the grant edge; BUSY holds the registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
    end else if (grant_d) begin
      // read+write together is a writeback; the refill follows as a later request
      bus.pmem_read    <= ~bus.d_write;
      bus.pmem_write   <= bus.d_write;
      bus.pmem_address <= {bus.d_address[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      if (bus.d_write) begin
        bus.pmem_wdata <= bus.d_wdata;
      end
    end else if (grant_i) begin
      bus.pmem_read    <= 1'b1;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= {bus.i_address[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    end else if (bus.pmem_resp && (state_q == BUSY_I || state_q == BUSY_D)) begin
      bus.pmem_read  <= 1'b0;
      bus.pmem_write <= 1'b0;
    end
  end

  assign bus.i_resp  = (state_q == BUSY_I) && bus.pmem_resp;
  assign bus.d_resp  = (state_q == BUSY_D) && bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
  assign arb_owner   = state_q;
endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Scoreboard bench for lc3b_mem_arbiter: drivers queue expected line transactions,
// a negedge monitor checks grants, pmem strobes and responses against a timing/priority model.
module tb_lc3b_mem_arbiter;
  localparam int unsigned LIMIT = 4;
`ifdef LC3B_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] arb_owner;

  lc3b_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

  lc3b_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .arb_owner (arb_owner)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  txn_t        exp_i[$];
  txn_t        exp_d[$];
  bit          grant_log[$];
  logic        ip_snap, dp_snap;
  bit          mon_en = 1'b0;
  bit          abort = 1'b0;
  int unsigned mem_lat = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] line_of(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [15:0] align(input logic [15:0] a);
    return {a[15:4], 4'h0};
  endfunction

  always @(posedge clk) begin
    ip_snap <= bus.i_read;
    dp_snap <= bus.d_read | bus.d_write;
  end

  // Reference model: D wins unless the guard has seen LIMIT D grants while I waited;
  // a new grant is possible only from the third cycle after a response (DONE + IDLE).
  bit          busy = 1'b0;
  bit          cur_d = 1'b0;
  txn_t        cur;
  int unsigned gap = 3;
  int unsigned starve = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) begin
        if (gap < 3) gap++;
        if (gap == 3 && (ip_snap || dp_snap)) begin
          cur_d = dp_snap && !(GUARD && ip_snap && starve == LIMIT);
          if (!ip_snap)   starve = 0;
          else if (cur_d) starve++;
          else            starve = 0;
          chk("pending_txn", 128'(cur_d ? exp_d.size() : exp_i.size()) != 0, 128'(1));
          if (cur_d && exp_d.size() != 0)       cur = exp_d[0];
          else if (!cur_d && exp_i.size() != 0) cur = exp_i[0];
          grant_log.push_back(cur_d);
          busy = 1'b1;
        end else begin
          chk("idle_strobe", 128'({bus.pmem_write, bus.pmem_read}), 128'(0));
          chk("idle_owner", 128'(arb_owner), 128'(gap == 1 ? 2'b11 : 2'b00));
          chk("idle_resp", 128'({bus.i_resp, bus.d_resp}), 128'(0));
        end
      end
      if (busy) begin
        chk("pmem_strobes", 128'({bus.pmem_write, bus.pmem_read}), 128'({cur.wr, ~cur.wr}));
        chk("pmem_address", 128'(bus.pmem_address), 128'(cur.addr));
        if (cur.wr) chk("pmem_wdata", bus.pmem_wdata, cur.wdata);
        chk("owner_busy", 128'(arb_owner), 128'(cur_d ? 2'b10 : 2'b01));
        chk("i_resp", 128'(bus.i_resp), 128'(bus.pmem_resp & ~cur_d));
        chk("d_resp", 128'(bus.d_resp), 128'(bus.pmem_resp & cur_d));
        if (bus.pmem_resp) begin
          if (!cur.wr && cur_d)  chk("d_rdata", bus.d_rdata, line_of(cur.addr));
          if (!cur.wr && !cur_d) chk("i_rdata", bus.i_rdata, line_of(cur.addr));
          if (cur_d && exp_d.size() != 0)       void'(exp_d.pop_front());
          else if (!cur_d && exp_i.size() != 0) void'(exp_i.pop_front());
          busy = 1'b0;
          gap  = 0;
        end
      end
    end
  end

  task automatic do_i(input logic [15:0] a);
    int unsigned t = 0;
    exp_i.push_back('{1'b0, align(a), 128'h0});
    bus.i_address = a;
    bus.i_read    = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.i_resp) break;
      if (arb_owner == 2'b01) bus.i_address = 16'($urandom);
      t++;
      if (abort) break;
      if (t > 2000) begin
        n_cmp++; n_err++;
        $display("FAIL i_resp_timeout: none after %0d cycles, required within 2000", t);
        abort = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_read = 1'b0;
  endtask

  task automatic do_d(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] w);
    int unsigned t = 0;
    exp_d.push_back('{wr, align(a), w});
    bus.d_address = a;
    bus.d_wdata   = w;
    bus.d_read    = rd;
    bus.d_write   = wr;
    forever begin
      @(negedge clk);
      if (bus.d_resp) break;
      if (arb_owner == 2'b10) begin
        bus.d_address = 16'($urandom);
        bus.d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      t++;
      if (abort) break;
      if (t > 2000) begin
        n_cmp++; n_err++;
        $display("FAIL d_resp_timeout: none after %0d cycles, required within 2000", t);
        abort = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic mem_responder();
    int unsigned l;
    logic [15:0] a;
    forever begin
      @(posedge clk); #1;
      if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
        l = (mem_lat != 0) ? mem_lat : $urandom_range(1, 4);
        a = bus.pmem_address;
        repeat (l) @(posedge clk);
        #1;
        bus.pmem_rdata = line_of(a);
        bus.pmem_resp  = 1'b1;
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  initial begin
    int first_i;
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 128'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, arb_owner}), 128'(0));
    chk("rst_address", 128'(bus.pmem_address), 128'(0));
    chk("rst_wdata", bus.pmem_wdata, 128'(0));

    // Reset in the middle of a D writeback, then a stray response after release.
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.d_write = 1'b1; bus.d_address = 16'h1008; bus.d_wdata = {16{8'hA5}};
    @(posedge clk); #1;
    chk("t1_grant_write", 128'({bus.pmem_write, bus.pmem_read}), 128'(2'b10));
    chk("t1_grant_addr", 128'(bus.pmem_address), 128'(16'h1000));
    @(negedge clk); #1;
    bus.pmem_resp = 1'b1;
    #1;
    chk("t1_d_resp_live", 128'(bus.d_resp), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t1_async_ctrl", 128'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, arb_owner}), 128'(0));
    chk("t1_async_addr", 128'(bus.pmem_address), 128'(0));
    chk("t1_async_wdata", bus.pmem_wdata, 128'(0));
    bus.pmem_resp = 1'b0;
    bus.d_write   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b1;
    #1;
    chk("t1_stray_resp", 128'({bus.i_resp, bus.d_resp}), 128'(0));
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    chk("t1_after_stray", 128'({bus.pmem_read, bus.pmem_write, arb_owner}), 128'(0));

    mon_en = 1'b1;
    fork
      mem_responder();
    join_none

    // Single I miss with fixed memory latency.
    mem_lat = 5;
    @(posedge clk); #1;
    do_i(16'h3A57);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous I read and D writeback: D goes first.
    mem_lat = 2;
    fork
      do_i(16'h2468);
      do_d(1'b0, 1'b1, 16'h1008, {16{8'hA5}});
    join
    @(posedge clk); #1;
    do_d(1'b1, 1'b1, 16'h7777, {$urandom, $urandom, $urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;

    // I held against continuous D reads.
    mem_lat = 1;
    grant_log.delete();
    fork
      do_i(16'h0BEE);
      begin
        for (int k = 0; k < 10; k++) begin
          do_d(1'b1, 1'b0, 16'(16'h4000 + 16 * k), 128'h0);
          @(posedge clk); #1;
        end
      end
    join
    first_i = -1;
    for (int k = 0; k < grant_log.size(); k++) begin
      if (!grant_log[k] && first_i < 0) first_i = k;
    end
    chk("t6_d_grants_before_i", 128'(first_i), 128'(GUARD ? LIMIT : 10));

    // Randomized mixed traffic.
    mem_lat = 0;
    fork
      begin
        for (int k = 0; k < 30 && !abort; k++) begin
          repeat (1 + $urandom_range(0, 3)) @(posedge clk);
          #1;
          do_i(16'($urandom));
        end
      end
      begin
        int unsigned op;
        for (int k = 0; k < 30 && !abort; k++) begin
          repeat (1 + $urandom_range(0, 3)) @(posedge clk);
          #1;
          op = $urandom_range(0, 2);
          do_d(op != 1, op != 0, 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end
      end
    join

    repeat (6) @(posedge clk);
    #1;
    chk("sb_i_drained", 128'(exp_i.size()), 128'(0));
    chk("sb_d_drained", 128'(exp_d.size()), 128'(0));
    chk("final_idle_owner", 128'(arb_owner), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end
endmodule
